ccr_gen: RTL and testbench
==========================

Name: ccr_gen

Overview:
- Condition-code producer for the 3-stage pipeline; the write side of the flags word that the branch-condition evaluator consumes.
- Computes z/n/c/v from the execute-stage ALU result and holds them in the architectural CCR.
- Provides a same-cycle bypass so a branch in decode sees flags from the instruction now in execute.
- Optional one-level shadow for interrupt entry and return.

Parameters:
- DATA_W, 32, ALU result width in bits (at least 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage holds a real instruction.
- ex_setcc  in  1  that instruction updates the flags.
- ex_op_class  in  2  00 logic, 01 add, 10 sub, 11 shift.
- ex_result  in  DATA_W  ALU result.
- ex_carry_out  in  1  adder carry out. For sub the adder computes a + ~b + 1.
- ex_shift_out  in  1  last bit shifted out.
- ex_a_msb  in  1  operand A sign bit.
- ex_b_msb  in  1  operand B sign bit, before inversion.
- stall  in  1  pipeline hold; execute instruction is re-presented next cycle.
- flush  in  1  execute instruction is squashed.
- cc_wr  in  1  explicit CCR write (move-to-CCR in execute).
- cc_wdata  in  4  value for cc_wr.
- irq_save  in  1  interrupt entry (shadow feature only).
- irq_restore  in  1  return from interrupt (shadow feature only).
- cc4  out  4  registered CCR. Bit order: 0=z, 1=n, 2=c, 3=v.
- cc4_fwd  out  4  combinational next CCR value, for decode-stage branch evaluation.
- cc_err  out  1  sticky shadow-protocol error.

Behaviour:
- Reset (async, rst_n=0):
  - cc4=4'b0000, shadow=0, FSM=RUN, cc_err=0.
  - cc4_fwd follows the same rules, so it reads 0 while in reset with no update.
- Flag computation (cand), with r = ex_result:
  - z = (r == 0); n = r[DATA_W-1].
  - add: c = ex_carry_out; v = (a_msb == b_msb) & (n != a_msb).
  - sub: c = ex_carry_out (1 = no borrow); v = (a_msb != b_msb) & (n != a_msb).
  - logic: c = cc4[2] (unchanged); v = 0.
  - shift: c = ex_shift_out; v = 0.
- Update enable:
  - upd = ex_valid & ex_setcc & ~stall & ~flush.
  - wr = cc_wr & ex_valid & ~stall & ~flush.
- Next-value priority, highest first:
  1. restore (shadow feature only)
  2. wr → cc_wdata
  3. upd → cand
  4. hold cc4
- cc4_fwd always equals that next value. cc4 <= cc4_fwd at each clock edge, so flags reach cc4 with 1-cycle latency and are zero-latency on cc4_fwd.
- wr and upd both set: wr wins; cand is discarded.
- stall or flush blocks both wr and upd; cc4 holds.
- Without the shadow feature: irq_save and irq_restore are ignored, and cc_err is tied to 0.

Optional Feature:
- Macro: CCR_SHADOW_EN.
- Defined: 1-entry shadow plus 2-state FSM (RUN, SAVED).
  - RUN & irq_save: shadow <= cc4_fwd, so an in-flight update is not lost; go to SAVED.
  - SAVED & irq_restore: next CCR = shadow (overrides wr/upd and ignores stall/flush); go to RUN.
  - SAVED & irq_save (nesting): cc_err <= 1; shadow unchanged; stay SAVED.
  - RUN & irq_restore: cc_err <= 1; no CCR change.
  - irq_save and irq_restore together: restore processed first, then save captures the restored value; end in SAVED.
  - cc_err clears only on reset.
- Not defined: no shadow register, no FSM; cc_err = 0.

Test Plan:
- Reset then DATA_W=32 add, a=32'h7FFFFFFF, b=1, result=32'h80000000, carry=0, setcc=1 → cc4_fwd=4'b1010 (v=1, n=1) the same cycle; cc4=4'b1010 one cycle later.
- Sub 5-5: result=0, carry=1, msbs 0 → cc4=4'b0101 (z=1, c=1). Then logic op with result=32'hFFFF0000 → cc4=4'b0110 (n=1, c kept, v=0).
- Add with setcc=1 and flush=1, then stall=1 → cc4 unchanged both cycles. Next, the same add with stall=0 → update applied.
- cc_wr=1, cc_wdata=4'b1111 together with upd producing 0000 → cc4=4'b1111.
- CCR_SHADOW_EN, cc4=4'b0001:
  - irq_save alongside an add giving 4'b0100 → shadow=0100.
  - Then write 1000; then irq_restore → cc4=4'b0100, FSM=RUN.
- CCR_SHADOW_EN: two irq_save pulses with no restore between → cc_err=1 from the second edge; assert rst_n=0 mid-sequence → cc_err=0, cc4=0 immediately.

Source files
------------

// File: rtl/ccr_gen_if.sv
// ccr_gen_if: execute-stage bus into the condition-code producer.
// Carries the ALU result and side-band bits, pipeline control, the explicit
// CCR write, interrupt save/restore strobes and the flag outputs.
// master = execute stage / pipeline control, slave = ccr_gen.

interface ccr_gen_if #(
  parameter int DATA_W = 32
);
  logic              ex_valid;
  logic              ex_setcc;
  logic [1:0]        ex_op_class;
  logic [DATA_W-1:0] ex_result;
  logic              ex_carry_out;
  logic              ex_shift_out;
  logic              ex_a_msb;
  logic              ex_b_msb;
  logic              stall;
  logic              flush;
  logic              cc_wr;
  logic [3:0]        cc_wdata;
  logic              irq_save;
  logic              irq_restore;
  logic [3:0]        cc4;
  logic [3:0]        cc4_fwd;
  logic              cc_err;

  modport master (
    output ex_valid, ex_setcc, ex_op_class, ex_result, ex_carry_out,
           ex_shift_out, ex_a_msb, ex_b_msb, stall, flush, cc_wr, cc_wdata,
           irq_save, irq_restore,
    input  cc4, cc4_fwd, cc_err
  );

  modport slave (
    input  ex_valid, ex_setcc, ex_op_class, ex_result, ex_carry_out,
           ex_shift_out, ex_a_msb, ex_b_msb, stall, flush, cc_wr, cc_wdata,
           irq_save, irq_restore,
    output cc4, cc4_fwd, cc_err
  );
endinterface

// File: rtl/ccr_gen.sv
// ccr_gen: condition-code producer for the 3-stage pipeline.
// Derives z/n/c/v from the execute-stage ALU result, holds them in the
// architectural CCR (cc4, bit 0=z 1=n 2=c 3=v) and exposes the next CCR
// value combinationally on cc4_fwd so a branch in decode sees it at once.
// Optional feature macro: CCR_SHADOW_EN adds a one-entry shadow CCR with a
// RUN/SAVED state machine for interrupt entry/return and a sticky protocol
// error flag. Without it irq_save/irq_restore are ignored and cc_err is 0.

module ccr_gen #(
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  ccr_gen_if.slave  bus
);

  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  logic [3:0] cc4_r;
  logic [3:0] next_s;
  logic [3:0] cand_s;
  logic       z_s;
  logic       n_s;
  logic       c_s;
  logic       v_s;
  logic       go_s;
  logic       upd_s;
  logic       wr_s;
  logic       restore_s;
  logic [3:0] restore_val_s;

  // Candidate flags from the current execute-stage result.
  always_comb begin
    z_s = (bus.ex_result == {DATA_W{1'b0}});
    n_s = bus.ex_result[DATA_W-1];
    c_s = cc4_r[2];
    v_s = 1'b0;
    case (bus.ex_op_class)
      OP_LOGIC: begin
        c_s = cc4_r[2];
        v_s = 1'b0;
      end
      OP_ADD: begin
        // Same-sign operands producing an opposite-sign result overflow.
        c_s = bus.ex_carry_out;
        v_s = (bus.ex_a_msb == bus.ex_b_msb) & (n_s != bus.ex_a_msb);
      end
      OP_SUB: begin
        // Adder computes a + ~b + 1, so carry set means no borrow.
        c_s = bus.ex_carry_out;
        v_s = (bus.ex_a_msb != bus.ex_b_msb) & (n_s != bus.ex_a_msb);
      end
      OP_SHIFT: begin
        c_s = bus.ex_shift_out;
        v_s = 1'b0;
      end
      default: begin
        c_s = cc4_r[2];
        v_s = 1'b0;
      end
    endcase
  end

  assign cand_s = {v_s, c_s, n_s, z_s};

  // A held or squashed instruction must not touch the flags.
  assign go_s  = bus.ex_valid & ~bus.stall & ~bus.flush;
  assign upd_s = go_s & bus.ex_setcc;
  assign wr_s  = go_s & bus.cc_wr;

`ifdef CCR_SHADOW_EN

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SAVED = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] shadow_r;
  logic [3:0] shadow_nxt_s;
  logic       err_set_s;
  logic       cc_err_r;

  // Restore is only legal from SAVED; it overrides stall/flush.
  assign restore_s     = (state_r == ST_SAVED) & bus.irq_restore;
  assign restore_val_s = shadow_r;

  // Shadow state machine: restore is resolved before save in the same cycle.
  always_comb begin
    state_nxt_s  = state_r;
    shadow_nxt_s = shadow_r;
    err_set_s    = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (bus.irq_restore) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = 1'b0;
        end
        if (bus.irq_save) begin
          // Capture the forwarded value so an in-flight update is kept.
          shadow_nxt_s = next_s;
          state_nxt_s  = ST_SAVED;
        end else begin
          state_nxt_s  = ST_RUN;
        end
      end
      ST_SAVED: begin
        if (bus.irq_restore) begin
          if (bus.irq_save) begin
            // Re-save after restore: captures the value just restored.
            shadow_nxt_s = next_s;
            state_nxt_s  = ST_SAVED;
          end else begin
            state_nxt_s  = ST_RUN;
          end
        end else if (bus.irq_save) begin
          // Nested save: shadow is only one deep, keep the original.
          err_set_s   = 1'b1;
          state_nxt_s = ST_SAVED;
        end else begin
          state_nxt_s = ST_SAVED;
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        shadow_nxt_s = shadow_r;
        err_set_s    = 1'b1;
      end
    endcase
  end

  // Shadow FSM state, shadow CCR and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      shadow_r <= 4'b0000;
      cc_err_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shadow_r <= shadow_nxt_s;
      cc_err_r <= cc_err_r | err_set_s;
    end
  end

  assign bus.cc_err = cc_err_r;

`else

  logic irq_unused_s;

  assign irq_unused_s  = bus.irq_save | bus.irq_restore;
  assign restore_s     = 1'b0;
  assign restore_val_s = 4'b0000;
  assign bus.cc_err    = 1'b0;

`endif

  // Next CCR value: restore, then explicit write, then flag update, else hold.
  always_comb begin
    next_s = cc4_r;
    if (restore_s) begin
      next_s = restore_val_s;
    end else if (wr_s) begin
      next_s = bus.cc_wdata;
    end else if (upd_s) begin
      next_s = cand_s;
    end else begin
      next_s = cc4_r;
    end
  end

  // Architectural CCR takes the forwarded next value every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc4_r <= 4'b0000;
    end else begin
      cc4_r <= next_s;
    end
  end

  assign bus.cc4     = cc4_r;
  assign bus.cc4_fwd = next_s;

endmodule

// File: tb/tb_ccr_gen.sv
// tb_ccr_gen: scoreboard bench for ccr_gen. Stimulus is described as ALU
// operands; the bench derives result/carry/overflow with wide signed and
// unsigned arithmetic and keeps a flag-level reference model. Expected
// cc4_fwd and registered cc4/cc_err values are queued and checked by two
// monitor processes. Handles both builds (CCR_SHADOW_EN defined or not).

module tb_ccr_gen;

  localparam int DATA_W = 32;

  logic clk;
  logic rst_n;

  ccr_gen_if #(.DATA_W(DATA_W)) bus ();

  ccr_gen #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic              setcc;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              shout;
    logic              stall;
    logic              flush;
    logic              wr;
    logic [3:0]        wdata;
    logic              save;
    logic              restore;
  } stim_t;

  typedef struct {
    logic [3:0] cc;
    logic       err;
  } reg_exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] fwd_q[$];
  reg_exp_t   reg_q[$];

  // Reference model state
  logic [3:0] m_cc;
  logic       m_saved;
  logic [3:0] m_shadow;
  logic       m_err;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s.valid = 1'b0; s.setcc = 1'b0; s.op = 2'b00;
    s.a = '0; s.b = '0; s.shout = 1'b0;
    s.stall = 1'b0; s.flush = 1'b0; s.wr = 1'b0; s.wdata = 4'b0000;
    s.save = 1'b0; s.restore = 1'b0;
    return s;
  endfunction

  function automatic stim_t alu_s(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
    stim_t s;
    s = idle_s();
    s.valid = 1'b1; s.setcc = 1'b1; s.op = op; s.a = a; s.b = b;
    return s;
  endfunction

  function automatic stim_t wr_s(input logic [3:0] d);
    stim_t s;
    s = idle_s();
    s.valid = 1'b1; s.wr = 1'b1; s.wdata = d;
    return s;
  endfunction

  task automatic drive_idle();
    bus.ex_valid = 1'b0; bus.ex_setcc = 1'b0; bus.ex_op_class = 2'b00;
    bus.ex_result = '0; bus.ex_carry_out = 1'b0; bus.ex_shift_out = 1'b0;
    bus.ex_a_msb = 1'b0; bus.ex_b_msb = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.cc_wr = 1'b0; bus.cc_wdata = 4'b0000; bus.irq_save = 1'b0; bus.irq_restore = 1'b0;
  endtask

  // Drive one instruction, advance the model, queue the expectations.
  task automatic apply(input stim_t s);
    logic [DATA_W-1:0] r;
    logic [DATA_W:0]   wide;
    logic              c;
    logic              v;
    longint            sa;
    longint            sb;
    longint            exact;
    logic [3:0]        cand;
    logic [3:0]        nxt;
    logic              ok;
    logic              saved_after;
    reg_exp_t          e;
    sa = longint'($signed(s.a));
    sb = longint'($signed(s.b));
    case (s.op)
      2'b01: begin
        wide  = {1'b0, s.a} + {1'b0, s.b};
        r     = wide[DATA_W-1:0];
        c     = wide[DATA_W];
        exact = sa + sb;
        v     = (exact != longint'($signed(r)));
      end
      2'b10: begin
        r     = s.a - s.b;
        c     = (s.a >= s.b);
        exact = sa - sb;
        v     = (exact != longint'($signed(r)));
      end
      2'b00: begin
        r = s.a; c = m_cc[2]; v = 1'b0;
      end
      default: begin
        r = s.a; c = s.shout; v = 1'b0;
      end
    endcase
    cand = {v, c, r[DATA_W-1], (r == '0)};

    bus.ex_valid     = s.valid;
    bus.ex_setcc     = s.setcc;
    bus.ex_op_class  = s.op;
    bus.ex_result    = r;
    bus.ex_carry_out = (s.op == 2'b01 || s.op == 2'b10) ? c : 1'($urandom_range(0, 1));
    bus.ex_shift_out = (s.op == 2'b11) ? s.shout : 1'($urandom_range(0, 1));
    bus.ex_a_msb     = s.a[DATA_W-1];
    bus.ex_b_msb     = s.b[DATA_W-1];
    bus.stall        = s.stall;
    bus.flush        = s.flush;
    bus.cc_wr        = s.wr;
    bus.cc_wdata     = s.wdata;
    bus.irq_save     = s.save;
    bus.irq_restore  = s.restore;

    ok  = s.valid & ~s.stall & ~s.flush;
    nxt = m_cc;
    if (ok && s.setcc) nxt = cand;
    if (ok && s.wr)    nxt = s.wdata;
`ifdef CCR_SHADOW_EN
    saved_after = m_saved;
    if (s.restore) begin
      if (m_saved) begin
        nxt = m_shadow;
        saved_after = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (s.save) begin
      if (!saved_after) begin
        m_shadow = nxt;
        saved_after = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    m_saved = saved_after;
`else
    saved_after = 1'b0;
`endif
    m_cc = nxt;
    fwd_q.push_back(nxt);
    e.cc  = nxt;
    e.err = m_err;
    reg_q.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #2;
    apply(s);
  endtask

  task automatic model_reset();
    m_cc = 4'b0000; m_saved = 1'b0; m_shadow = 4'b0000; m_err = 1'b0;
  endtask

  // Monitor: registered outputs after each edge.
  initial begin
    reg_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        check4("cc4", bus.cc4, e.cc);
        check1("cc_err", bus.cc_err, e.err);
      end
    end
  end

  // Monitor: forwarded value once inputs have settled.
  initial begin
    logic [3:0] f;
    forever begin
      @(posedge clk);
      #4;
      if (fwd_q.size() > 0) begin
        f = fwd_q.pop_front();
        check4("cc4_fwd", bus.cc4_fwd, f);
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    drive_idle();
    rst_n = 1'b0;
    #3;
    check4("reset_cc4", bus.cc4, 4'b0000);
    check4("reset_fwd", bus.cc4_fwd, 4'b0000);
    check1("reset_err", bus.cc_err, 1'b0);
    #9;
    rst_n = 1'b1;

    // Signed overflow on add: 7FFFFFFF + 1
    step(alu_s(2'b01, 32'h7FFF_FFFF, 32'h0000_0001));
    #1;
    check4("tp_add_fwd", bus.cc4_fwd, 4'b1010);
    step(idle_s());
    check4("tp_add_reg", bus.cc4, 4'b1010);

    // 5-5 then logic op keeping carry
    step(alu_s(2'b10, 32'd5, 32'd5));
    step(alu_s(2'b00, 32'hFFFF_0000, 32'h0000_0000));
    check4("tp_sub_reg", bus.cc4, 4'b0101);
    step(idle_s());
    check4("tp_logic_reg", bus.cc4, 4'b0110);

    // Flushed, then stalled, then real add
    s = alu_s(2'b01, 32'd3, 32'd4);
    s.flush = 1'b1;
    step(s);
    s.flush = 1'b0;
    s.stall = 1'b1;
    step(s);
    check4("tp_flush_reg", bus.cc4, 4'b0110);
    s.stall = 1'b0;
    step(s);
    check4("tp_stall_reg", bus.cc4, 4'b0110);
    #1;
    check4("tp_go_fwd", bus.cc4_fwd, 4'b0000);
    step(idle_s());
    check4("tp_go_reg", bus.cc4, 4'b0000);

    // Explicit write beats a concurrent flag update
    s = alu_s(2'b01, 32'd3, 32'd4);
    s.wr = 1'b1;
    s.wdata = 4'b1111;
    step(s);
    step(idle_s());
    check4("tp_wr_wins", bus.cc4, 4'b1111);

`ifdef CCR_SHADOW_EN
    step(wr_s(4'b0001));
    s = alu_s(2'b01, 32'd2, 32'hFFFF_FFFF);
    s.save = 1'b1;
    step(s);
    step(wr_s(4'b1000));
    s = idle_s();
    s.restore = 1'b1;
    step(s);
    check4("tp_pre_restore", bus.cc4, 4'b1000);
    step(idle_s());
    check4("tp_restore", bus.cc4, 4'b0100);
    check1("tp_restore_err", bus.cc_err, 1'b0);
    s = idle_s();
    s.save = 1'b1;
    step(s);
    step(s);
    step(idle_s());
    check1("tp_nest_err", bus.cc_err, 1'b1);
`endif

    // Reset asserted mid-sequence clears everything at once
    step(wr_s(4'b1011));
    @(posedge clk);
    #2;
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check4("midrst_cc4", bus.cc4, 4'b0000);
    check4("midrst_fwd", bus.cc4_fwd, 4'b0000);
    check1("midrst_err", bus.cc_err, 1'b0);
    #1;
    rst_n = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      s = idle_s();
      s.valid   = ($urandom_range(0, 7) != 0);
      s.setcc   = ($urandom_range(0, 3) != 0);
      s.op      = 2'($urandom_range(0, 3));
      s.a       = $urandom();
      s.b       = $urandom();
      case ($urandom_range(0, 5))
        0: s.b = s.a;
        1: s.a = 32'h7FFF_FFFF;
        2: s.a = 32'h8000_0000;
        3: s.a = 32'h0000_0000;
        default: s.b = s.b;
      endcase
      s.shout   = 1'($urandom_range(0, 1));
      s.stall   = ($urandom_range(0, 5) == 0);
      s.flush   = ($urandom_range(0, 7) == 0);
      s.wr      = ($urandom_range(0, 7) == 0);
      s.wdata   = 4'($urandom_range(0, 15));
      s.save    = ($urandom_range(0, 11) == 0);
      s.restore = ($urandom_range(0, 11) == 0);
      step(s);
    end

    step(idle_s());
    @(posedge clk);
    @(posedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
